m_shift_pipe: RTL and testbench
===============================

Name: m_shift_pipe

Overview:
- Parametrised serial/parallel shift register. Successor of the team's fixed 4-stage, 1-bit shift chain.
- Adds:
  - configurable word width and depth
  - shift enable
  - parallel load
  - left/right shift and rotate modes
  - fill counter and full flag
- Used as a programmable delay line and serialiser/deserialiser in the single-cycle and pipeline lab designs.

Parameters:
- WIDTH, 1, bits per stage (>=1)
- DEPTH, 4, number of stages (>=1)
- CW, $clog2(DEPTH+1), fill counter width (derived; do not override)

Ports:
- w_clk  input  1  rising-edge clock
- w_rst_n  input  1  asynchronous active-low reset
- w_en  input  1  shift/rotate enable
- w_mode  input  2  00 shift right, 01 shift left, 10 rotate right, 11 rotate left
- w_load  input  1  parallel load strobe
- w_pdata  input  WIDTH*DEPTH  parallel load data; stage i = bits [i*WIDTH +: WIDTH]
- w_in  input  WIDTH  serial input word
- w_out  output  WIDTH  serial output word
- w_q  output  WIDTH*DEPTH  parallel view of all stages, same packing as w_pdata
- w_fill  output  CW  number of stages holding data written since reset
- w_full  output  1  w_fill == DEPTH

Behaviour:
- Storage: stage array s[0..DEPTH-1], WIDTH bits each. All state is updated only on posedge w_clk or negedge w_rst_n.
- Reset:
  - w_rst_n=0 immediately clears all stages and w_fill, independent of the clock.
  - Therefore w_out=0, w_q=0, w_fill=0, w_full=0.
  - Holds while low; first update occurs on the first rising edge after release.
- Reset mid-operation: contents are lost; no partial shift completes.
- Priority at a rising edge: w_load > w_en > hold.
- Load (w_load=1):
  - s[i] <= w_pdata stage i for all i; w_fill <= DEPTH.
  - w_en, w_mode and w_in are ignored that cycle.
- Shift right (w_en=1, mode 00):
  - s[DEPTH-1] <= w_in; s[i] <= s[i+1] for i<DEPTH-1.
  - Old s[0] is discarded.
- Shift left (mode 01):
  - s[0] <= w_in; s[i] <= s[i-1] for i>0.
  - Old s[DEPTH-1] is discarded.
- Rotate right (mode 10): s[DEPTH-1] <= s[0]; other stages shift as in shift right. w_in is ignored.
- Rotate left (mode 11): s[0] <= s[DEPTH-1]; other stages shift as in shift left. w_in is ignored.
- Hold (w_load=0, w_en=0): all state unchanged.
- w_out is a combinational mux of registered state (no extra latency):
  - s[0] when w_mode[0]=0 (right modes)
  - s[DEPTH-1] when w_mode[0]=1 (left modes)
- Latency: a word presented on w_in at shift edge k appears on w_out after shift edge k+DEPTH-1, i.e. DEPTH enabled edges including its own.
  - Disabled cycles stretch the latency and lose no data.
- Fill counter:
  - Shift modes: w_fill <= min(w_fill+1, DEPTH). Saturates, never wraps.
  - Rotate modes and hold: unchanged.
  - Load: DEPTH.
  - w_full is combinational from w_fill.
- Mode change between edges: takes effect at the next enabled edge; no flush, no data reordering beyond the new mode's rule.
- DEPTH=1: left and right variants are identical.
  - Shift: s[0] <= w_in.
  - Rotate: s[0] holds its value.
- No X propagation: every stage has a defined reset value. Unused w_mode encodings do not exist (all four are defined).

Test Plan:
- WIDTH=1, DEPTH=4, reset low then released:
  - Sequence: w_en=1, mode 00, w_in=1 held.
  - w_out=0 after edges 1-3, w_out=1 after edge 4.
  - w_fill steps 1,2,3,4; w_full=1 from edge 4.
- WIDTH=8, DEPTH=4, mode 00:
  - Sequence: w_in=0x11,0x22,0x33,0x44 on 4 enabled edges, with one w_en=0 cycle inserted after 0x22.
  - Final state: w_q={0x44,0x33,0x22,0x11} (stage 3 down to 0), w_out=0x11.
  - The disabled cycle holds all state.
- WIDTH=8, DEPTH=4, parallel load and rotate:
  - Load w_pdata=0x44332211 with w_en=1 asserted simultaneously: load wins, w_q=0x44332211, w_fill=4.
  - Then mode 10, 4 enabled edges: w_out=0x22,0x33,0x44,0x11 after edges 1-4; w_fill stays 4.
- WIDTH=8, DEPTH=4, mode 01 after loading 0x44332211:
  - w_in=0xAA, one edge: w_q=0x332211AA, w_out=s[3]=0x33.
- Async reset mid-stream:
  - Pull w_rst_n low between clock edges with w_fill=3.
  - w_q=0 and w_fill=0 before the next edge.
  - After release, the first enabled edge gives w_fill=1.
- DEPTH=1, WIDTH=4:
  - Mode 00, w_in=0x5: w_out=0x5 after one edge.
  - Mode 10: w_out holds 0x5 over 3 edges.
  - Saturation: w_fill stays 1 over 5 shift edges.

Source files
------------

// File: rtl/m_shift_pipe.sv
// m_shift_pipe: parametrised serial/parallel shift register with shift/rotate
// modes, parallel load, and a saturating fill counter. Stage i occupies
// bits [i*WIDTH +: WIDTH] of both w_pdata and w_q.
module m_shift_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   w_clk,
  input  logic                   w_rst_n,
  input  logic                   w_en,
  input  logic [1:0]             w_mode,
  input  logic                   w_load,
  input  logic [WIDTH*DEPTH-1:0] w_pdata,
  input  logic [WIDTH-1:0]       w_in,
  output logic [WIDTH-1:0]       w_out,
  output logic [WIDTH*DEPTH-1:0] w_q,
  output logic [CW-1:0]          w_fill,
  output logic                   w_full
);

  localparam int QW = WIDTH * DEPTH;
  localparam logic [CW-1:0] FILL_MAX = CW'(DEPTH);

  typedef enum logic [1:0] {
    MODE_SHR = 2'b00,
    MODE_SHL = 2'b01,
    MODE_ROR = 2'b10,
    MODE_ROL = 2'b11
  } mode_e;

  logic [QW-1:0]    q_r;
  logic [QW-1:0]    q_nxt_s;
  logic [QW-1:0]    q_right_s;
  logic [QW-1:0]    q_left_s;
  logic [CW-1:0]    fill_r;
  logic [CW-1:0]    fill_nxt_s;
  logic [WIDTH-1:0] head_s;     // stage 0
  logic [WIDTH-1:0] tail_s;     // stage DEPTH-1
  logic [WIDTH-1:0] feed_s;     // word entering the vacated end
  logic             is_shift_s; // shift modes advance the fill counter, rotates do not

  assign head_s = q_r[WIDTH-1:0];
  assign tail_s = q_r[QW-1 -: WIDTH];

  // Choose the incoming word: serial input for shifts, the opposite end for rotates
  always_comb begin
    feed_s     = w_in;
    is_shift_s = 1'b1;
    case (w_mode)
      MODE_SHR: begin
        feed_s     = w_in;
        is_shift_s = 1'b1;
      end
      MODE_SHL: begin
        feed_s     = w_in;
        is_shift_s = 1'b1;
      end
      MODE_ROR: begin
        feed_s     = head_s;
        is_shift_s = 1'b0;
      end
      MODE_ROL: begin
        feed_s     = tail_s;
        is_shift_s = 1'b0;
      end
      default: begin
        feed_s     = w_in;
        is_shift_s = 1'b1;
      end
    endcase
  end

  // A single stage has no neighbours: both directions simply take the feed word
  generate
    if (DEPTH == 1) begin : g_single
      assign q_right_s = feed_s;
      assign q_left_s  = feed_s;
    end else begin : g_multi
      assign q_right_s = {feed_s, q_r[QW-1:WIDTH]};
      assign q_left_s  = {q_r[QW-WIDTH-1:0], feed_s};
    end
  endgenerate

  // Next-state selection with priority load > enabled shift/rotate > hold
  always_comb begin
    q_nxt_s    = q_r;
    fill_nxt_s = fill_r;
    if (w_load) begin
      q_nxt_s    = w_pdata;
      fill_nxt_s = FILL_MAX;
    end else if (w_en) begin
      if (w_mode[0]) begin
        q_nxt_s = q_left_s;
      end else begin
        q_nxt_s = q_right_s;
      end
      if (is_shift_s && (fill_r != FILL_MAX)) begin
        fill_nxt_s = fill_r + CW'(1);
      end else begin
        fill_nxt_s = fill_r;
      end
    end else begin
      q_nxt_s    = q_r;
      fill_nxt_s = fill_r;
    end
  end

  // Stage and fill-counter registers, cleared immediately by reset
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      q_r    <= '0;
      fill_r <= '0;
    end else begin
      q_r    <= q_nxt_s;
      fill_r <= fill_nxt_s;
    end
  end

  // Serial output taps the end the current direction shifts out of
  assign w_out  = w_mode[0] ? tail_s : head_s;
  assign w_q    = q_r;
  assign w_fill = fill_r;
  assign w_full = (fill_r == FILL_MAX);

endmodule

// File: tb/tb_m_shift_pipe.sv
// Directed bench for m_shift_pipe: three instances (1x4, 8x4, 4x1) sharing
// clock and reset, a vector table for the 8-bit pipe and hand sequences for
// reset, fill and single-stage corner cases.
module tb_m_shift_pipe;

  logic w_clk;
  logic w_rst_n;

  // 1-bit, 4-stage instance
  logic       a_en, a_load, a_in;
  logic [1:0] a_mode;
  logic [3:0] a_pdata, a_q;
  logic       a_out, a_full;
  logic [2:0] a_fill;

  // 8-bit, 4-stage instance
  logic        b_en, b_load;
  logic [1:0]  b_mode;
  logic [31:0] b_pdata, b_q;
  logic [7:0]  b_in, b_out;
  logic [2:0]  b_fill;
  logic        b_full;

  // 4-bit, 1-stage instance
  logic       c_en, c_load;
  logic [1:0] c_mode;
  logic [3:0] c_pdata, c_in, c_out, c_q;
  logic [0:0] c_fill;
  logic       c_full;

  int n_total = 0;
  int n_pass  = 0;

  m_shift_pipe #(.WIDTH(1), .DEPTH(4)) dut_a (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .w_en(a_en), .w_mode(a_mode), .w_load(a_load),
    .w_pdata(a_pdata), .w_in(a_in), .w_out(a_out), .w_q(a_q), .w_fill(a_fill), .w_full(a_full)
  );

  m_shift_pipe #(.WIDTH(8), .DEPTH(4)) dut_b (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .w_en(b_en), .w_mode(b_mode), .w_load(b_load),
    .w_pdata(b_pdata), .w_in(b_in), .w_out(b_out), .w_q(b_q), .w_fill(b_fill), .w_full(b_full)
  );

  m_shift_pipe #(.WIDTH(4), .DEPTH(1)) dut_c (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .w_en(c_en), .w_mode(c_mode), .w_load(c_load),
    .w_pdata(c_pdata), .w_in(c_in), .w_out(c_out), .w_q(c_q), .w_fill(c_fill), .w_full(c_full)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  typedef struct {
    logic        load;
    logic        en;
    logic [1:0]  mode;
    logic [31:0] pdata;
    logic [7:0]  din;
    logic [31:0] q;
    logic [7:0]  out;
    logic [2:0]  fill;
    logic        full;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // advance one rising edge and settle just after it
  task automatic cyc();
    @(posedge w_clk);
    #1;
  endtask

  initial begin
    // load, en, mode, pdata, in, exp q, exp out, exp fill, exp full
    vt[0]  = '{1'b0, 1'b1, 2'b00, 32'h0,        8'h11, 32'h11000000, 8'h00, 3'd1, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 2'b00, 32'h0,        8'h22, 32'h22110000, 8'h00, 3'd2, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 2'b00, 32'h0,        8'h99, 32'h22110000, 8'h00, 3'd2, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 2'b00, 32'h0,        8'h33, 32'h33221100, 8'h00, 3'd3, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 2'b00, 32'h0,        8'h44, 32'h44332211, 8'h11, 3'd4, 1'b1};
    vt[5]  = '{1'b1, 1'b0, 2'b00, 32'h0F0E0D0C, 8'h00, 32'h0F0E0D0C, 8'h0C, 3'd4, 1'b1};
    vt[6]  = '{1'b1, 1'b1, 2'b00, 32'h44332211, 8'hFF, 32'h44332211, 8'h11, 3'd4, 1'b1};
    vt[7]  = '{1'b0, 1'b1, 2'b10, 32'h0,        8'hEE, 32'h11443322, 8'h22, 3'd4, 1'b1};
    vt[8]  = '{1'b0, 1'b1, 2'b10, 32'h0,        8'hEE, 32'h22114433, 8'h33, 3'd4, 1'b1};
    vt[9]  = '{1'b0, 1'b1, 2'b10, 32'h0,        8'hEE, 32'h33221144, 8'h44, 3'd4, 1'b1};
    vt[10] = '{1'b0, 1'b1, 2'b10, 32'h0,        8'hEE, 32'h44332211, 8'h11, 3'd4, 1'b1};
    vt[11] = '{1'b0, 1'b1, 2'b01, 32'h0,        8'hAA, 32'h332211AA, 8'h33, 3'd4, 1'b1};
    vt[12] = '{1'b0, 1'b1, 2'b11, 32'h0,        8'h55, 32'h2211AA33, 8'h22, 3'd4, 1'b1};
    vt[13] = '{1'b0, 1'b0, 2'b01, 32'h0,        8'h77, 32'h2211AA33, 8'h22, 3'd4, 1'b1};

    w_rst_n = 1'b0;
    a_en = 1'b0; a_load = 1'b0; a_in = 1'b0; a_mode = 2'b00; a_pdata = 4'h0;
    b_en = 1'b0; b_load = 1'b0; b_in = 8'h00; b_mode = 2'b00; b_pdata = 32'h0;
    c_en = 1'b0; c_load = 1'b0; c_in = 4'h0; c_mode = 2'b00; c_pdata = 4'h0;

    // reset state
    #3;
    chk("rst_b_q", b_q, 32'h0);
    chk("rst_b_fill", {29'd0, b_fill}, 32'd0);
    chk("rst_b_full", {31'd0, b_full}, 32'd0);
    chk("rst_a_out", {31'd0, a_out}, 32'd0);
    chk("rst_c_out", {28'd0, c_out}, 32'd0);
    @(negedge w_clk);
    w_rst_n = 1'b1;

    // 1-bit delay line: a held 1 reaches w_out after the 4th enabled edge
    a_en = 1'b1; a_mode = 2'b00; a_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk($sformatf("a_out[%0d]", i), {31'd0, a_out}, (i == 4) ? 32'd1 : 32'd0);
      chk($sformatf("a_fill[%0d]", i), {29'd0, a_fill}, i);
      chk($sformatf("a_full[%0d]", i), {31'd0, a_full}, (i == 4) ? 32'd1 : 32'd0);
    end
    a_en = 1'b0;

    // 8-bit vector table
    for (int i = 0; i < NV; i++) begin
      b_load = vt[i].load; b_en = vt[i].en; b_mode = vt[i].mode;
      b_pdata = vt[i].pdata; b_in = vt[i].din;
      cyc();
      chk($sformatf("b_q[%0d]", i), b_q, vt[i].q);
      chk($sformatf("b_out[%0d]", i), {24'd0, b_out}, {24'd0, vt[i].out});
      chk($sformatf("b_fill[%0d]", i), {29'd0, b_fill}, {29'd0, vt[i].fill});
      chk($sformatf("b_full[%0d]", i), {31'd0, b_full}, {31'd0, vt[i].full});
    end
    b_load = 1'b0; b_en = 1'b0;

    // async reset mid-stream with fill=3
    w_rst_n = 1'b0;
    #2;
    w_rst_n = 1'b1;
    b_mode = 2'b00; b_en = 1'b1;
    b_in = 8'h01; cyc();
    b_in = 8'h02; cyc();
    b_in = 8'h03; cyc();
    chk("ar_pre_fill", {29'd0, b_fill}, 32'd3);
    b_en = 1'b0;
    #2;
    w_rst_n = 1'b0;
    #1;
    chk("ar_q", b_q, 32'h0);
    chk("ar_fill", {29'd0, b_fill}, 32'd0);
    chk("ar_full", {31'd0, b_full}, 32'd0);
    #2;
    w_rst_n = 1'b1;
    cyc();
    chk("ar_hold_q", b_q, 32'h0);
    b_en = 1'b1; b_in = 8'h77;
    cyc();
    chk("ar_first_fill", {29'd0, b_fill}, 32'd1);
    chk("ar_first_q", b_q, 32'h77000000);
    b_mode = 2'b10;
    cyc();
    chk("ar_rot_fill", {29'd0, b_fill}, 32'd1);
    chk("ar_rot_q", b_q, 32'h00770000);
    b_en = 1'b0; b_load = 1'b1; b_pdata = 32'hCAFEF00D;
    cyc();
    chk("ar_load_q", b_q, 32'hCAFEF00D);
    chk("ar_load_fill", {29'd0, b_fill}, 32'd4);
    chk("ar_load_full", {31'd0, b_full}, 32'd1);
    b_load = 1'b0;

    // single-stage pipe
    c_en = 1'b1; c_mode = 2'b00; c_in = 4'h5;
    cyc();
    chk("c_shr_out", {28'd0, c_out}, 32'h5);
    chk("c_fill", {31'd0, c_fill}, 32'd1);
    chk("c_full", {31'd0, c_full}, 32'd1);
    c_mode = 2'b10; c_in = 4'hA;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("c_ror_out[%0d]", i), {28'd0, c_out}, 32'h5);
    end
    c_mode = 2'b11;
    cyc();
    chk("c_rol_out", {28'd0, c_out}, 32'h5);
    c_mode = 2'b01; c_in = 4'h3;
    cyc();
    chk("c_shl_out", {28'd0, c_out}, 32'h3);
    c_mode = 2'b00;
    for (int i = 0; i < 5; i++) begin
      logic [3:0] v;
      v = 4'(i + 6);
      c_in = v;
      cyc();
      chk($sformatf("c_sat_fill[%0d]", i), {31'd0, c_fill}, 32'd1);
      chk($sformatf("c_sat_out[%0d]", i), {28'd0, c_out}, {28'd0, v});
    end
    c_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
